jtriders_prmix: RTL and testbench
=================================

# jtriders_prmix

Five-input priority mixer for the Riders board family. It sits directly downstream of the object layer and the tilemap layers, and upstream of the palette RAM. Each pixel slot it picks the highest-precedence opaque layer and forms an 11-bit palette address plus a shadow flag. Priorities, palette banks and shadow rules come from a CPU-written register file.

## Interface
Parameters:
- `BDW`, 8: backdrop colour width; value from register 5.

Ports:
- `clk`  in  1  system clock; sole clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `pxl_cen`  in  1  pixel clock enable; the pipeline advances only on it.
- `hs`  in  1  horizontal sync.
- `lhbl`  in  1  horizontal blank, active-low.
- `lvbl`  in  1  vertical blank, active-low.
- `cs`  in  1  register select.
- `cpu_we`  in  1  write strobe; a write happens on a clk edge with `cs & cpu_we`.
- `cpu_addr`  in  4  register index.
- `cpu_dout`  in  8  write data.
- `obj_pxl`  in  9  L0 object pixel: {colour[4:0], pen[3:0]}.
- `obj_prio`  in  5  L0 priority.
- `obj_shd`  in  1  L0 shadow request.
- `scr1_pxl`, `scr2_pxl`  in  8  L1/L2 tilemap pixels: {colour[3:0], pen[3:0]}.
- `scr1_prio`, `scr2_prio`  in  5  L1/L2 external priority.
- `scr3_pxl`, `scr4_pxl`  in  8  L3/L4 fixed-priority tilemaps.
- `pal_addr`  out  11  palette RAM address.
- `shd`  out  1  shadow for the current pixel.
- `st_addr`  in  4  debug register index.
- `st_dout`  out  8  debug readback of the active register set.

## Operation
- A pen of 0 is transparent for every layer.
- Effective priorities:
  - L0 uses `obj_prio`.
  - L1 and L2 use their port value when control bit0/bit1 is set; otherwise they use reg0/reg1.
  - L3 uses reg2; L4 uses reg3.
- Winner: the lowest numeric priority among opaque layers. On a tie, the lower layer index wins.
- If no layer is opaque, the output is the backdrop: `pal_addr = {reg8[2:0], reg5}`.
- Palette address by winner:
  - L0: `{reg6[1:0], obj_pxl}`.
  - L1: `{reg6[4:2], pxl}`. L2: `{reg7[2:0], pxl}`. L3: `{reg7[5:3], pxl}`. L4: `{reg8[5:3], pxl}`.
- Shadow: `shd = ctrl.bit2 & obj_shd & (winner_prio >= reg4)`. The comparison is unsigned 5-bit. A backdrop winner counts as priority 31.
- Blanking: if `~lhbl | ~lvbl` when the pixel enters stage 1, that pixel leaves as `pal_addr = 0`, `shd = 0`.
- Register map, 8-bit; unused bits ignored. Registers 10–15 are ignored on write and read 0 on `st_dout`.
  - 0–3: priority values, [4:0].
  - 4: shadow threshold.
  - 5: backdrop colour.
  - 6–8: bank registers.
  - 9: control. bit0/bit1 = L1/L2 priority from port; bit2 = shadow enable; bit3 = line-latch mode.
- Line latch:
  - bit3 = 0: writes go to the shadow set and the active set together.
  - bit3 = 1: writes go to the shadow set only. The whole shadow set copies to the active set on the clk after an `hs` rising edge, detected against a registered `hs`.
  - Register 9 always updates both sets immediately.
- Simultaneous write and `hs` copy: the written value reaches the active set in that same copy.

## Timing
- Stage 1, on `pxl_cen`: latch inputs and blank state; resolve transparency and effective priorities.
- Stage 2: comparator tree, giving winner index, its priority and its pixel.
- Stage 3: form the palette address and shadow flag; register the outputs.
- Latency is exactly 3 `pxl_cen` pulses from input to `pal_addr`/`shd`. Outputs hold between enables.
- Register writes take effect on the next clk. A pixel already in the pipeline uses the register values sampled at its stage-1 entry.
- Reset:
  - All registers, both sets, reset to 0.
  - The pipeline clears; `pal_addr = 0`, `shd = 0`, `st_dout = 0`.
  - Reset asserted mid-line aborts the pipeline immediately. The first valid output comes 3 `pxl_cen` after release.
- `st_dout` is registered and follows `st_addr` with 1 clk latency.

## Structure
- Package `jtriders_prmix_pkg` holds:
  - register index constants (`PRIO1`…`CTRL`) and control bit positions;
  - the layer count (5), the backdrop priority (31) and the palette address width (11).
- Sub-module `jtriders_prmix_cmp` is the registered stage-2 comparator. It takes 5 {valid, prio, pxl} tuples and gives {index, prio, pxl}, with the tie rule applied.
- The top level holds the register file, line latch, stage 1, stage 3 and debug readback.

## Test plan
- Reset release, all inputs opaque, all registers 0 → L0 wins the tie. Three `pxl_cen` later, `obj_pxl = 9'h1A5` gives `pal_addr = 11'h1A5`, `shd = 0`.
- reg2 = 3, reg3 = 1, `obj_prio = 5`, L1/L2 transparent → L4 wins. `scr4_pxl = 8'h37`, reg8 = 8'h28 gives `pal_addr = 11'h537`.
- All pens 0, reg5 = 8'hC4, reg8 = 3 → `pal_addr = 11'h3C4` (backdrop).
- reg9 = 4, reg4 = 8, `obj_shd = 1`, obj transparent:
  - winner L3 at priority 10 → `shd = 1`;
  - winner priority 6 → `shd = 0`.
- reg9 = 8 (line latch), write reg0 = 2 mid-line → old value stays active until the `hs` rise, then applies. A write in the same clk as the copy is active immediately.
- `lhbl` low for 1 pixel → exactly one output pixel is zero, 3 `pxl_cen` later.

Source files
------------

// File: rtl/jtriders_prmix_pkg.sv
// Shared constants and pipeline types for the Riders five-layer priority mixer.
package jtriders_prmix_pkg;

  localparam int NLAYERS = 5;
  localparam int NREGS   = 10;
  localparam int PAW     = 11;

  localparam logic [4:0] BD_PRIO  = 5'd31;
  localparam logic [2:0] IDX_NONE = 3'd5;

  localparam logic [3:0] PRIO1 = 4'd0;
  localparam logic [3:0] PRIO2 = 4'd1;
  localparam logic [3:0] PRIO3 = 4'd2;
  localparam logic [3:0] PRIO4 = 4'd3;
  localparam logic [3:0] SHTHR = 4'd4;
  localparam logic [3:0] BDCOL = 4'd5;
  localparam logic [3:0] BANK0 = 4'd6;
  localparam logic [3:0] BANK1 = 4'd7;
  localparam logic [3:0] BANK2 = 4'd8;
  localparam logic [3:0] CTRL  = 4'd9;

  localparam int CTL_P1    = 0;
  localparam int CTL_P2    = 1;
  localparam int CTL_SHD   = 2;
  localparam int CTL_LATCH = 3;

  typedef struct packed {
    logic       valid;
    logic [4:0] prio;
    logic [8:0] pxl;
  } layer_t;

  // Register-derived settings that travel with each pixel down the pipe
  typedef struct packed {
    logic           blank;
    logic           shd_en;
    logic [4:0]     thr;
    logic [1:0]     bank0;
    logic [2:0]     bank1;
    logic [2:0]     bank2;
    logic [2:0]     bank3;
    logic [2:0]     bank4;
    logic [PAW-1:0] backdrop;
  } cfg_t;

  function automatic logic opaque(input logic [3:0] pen);
    return pen != 4'd0;
  endfunction

endpackage

// File: rtl/jtriders_prmix_cmp.sv
// Registered comparator: picks the opaque layer with the lowest priority, lower index on ties.
module jtriders_prmix_cmp
  import jtriders_prmix_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      cen,
  input  layer_t [NLAYERS-1:0]      lyr,
  output logic [2:0]                win_idx,
  output logic                      win_found,
  output logic [4:0]                win_prio,
  output logic [8:0]                win_pxl
);

  logic [2:0] idx_d, idx_q;
  logic       found_d, found_q;
  logic [4:0] prio_d, prio_q;
  logic [8:0] pxl_d, pxl_q;

  // Strict less-than while scanning upward keeps the earlier layer on a tie
  always_comb begin
    idx_d   = IDX_NONE;
    found_d = 1'b0;
    prio_d  = BD_PRIO;
    pxl_d   = 9'd0;
    for (int i = 0; i < NLAYERS; i++) begin
      if (lyr[i].valid && (!found_d || lyr[i].prio < prio_d)) begin
        idx_d   = 3'(i);
        found_d = 1'b1;
        prio_d  = lyr[i].prio;
        pxl_d   = lyr[i].pxl;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q   <= IDX_NONE;
      found_q <= 1'b0;
      prio_q  <= BD_PRIO;
      pxl_q   <= 9'd0;
    end else if (cen) begin
      idx_q   <= idx_d;
      found_q <= found_d;
      prio_q  <= prio_d;
      pxl_q   <= pxl_d;
    end
  end

  assign win_idx   = idx_q;
  assign win_found = found_q;
  assign win_prio  = prio_q;
  assign win_pxl   = pxl_q;

endmodule

// File: rtl/jtriders_prmix.sv
// Riders priority mixer: register file with line latch, three-stage pixel pipeline, debug readback.
module jtriders_prmix
  import jtriders_prmix_pkg::*;
#(
  parameter int BDW = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           pxl_cen,
  input  logic           hs,
  input  logic           lhbl,
  input  logic           lvbl,
  input  logic           cs,
  input  logic           cpu_we,
  input  logic [3:0]     cpu_addr,
  input  logic [7:0]     cpu_dout,
  input  logic [8:0]     obj_pxl,
  input  logic [4:0]     obj_prio,
  input  logic           obj_shd,
  input  logic [7:0]     scr1_pxl,
  input  logic [7:0]     scr2_pxl,
  input  logic [4:0]     scr1_prio,
  input  logic [4:0]     scr2_prio,
  input  logic [7:0]     scr3_pxl,
  input  logic [7:0]     scr4_pxl,
  output logic [PAW-1:0] pal_addr,
  output logic           shd,
  input  logic [3:0]     st_addr,
  output logic [7:0]     st_dout
);

  logic [NREGS-1:0][7:0] shadow_d, shadow_q;
  logic [NREGS-1:0][7:0] active_d, active_q;
  logic                  hs_q;
  logic [7:0]            ctrl;

  assign ctrl = active_q[CTRL];

  // In latch mode the copy takes the post-write shadow so a same-clock write lands too
  always_comb begin
    shadow_d = shadow_q;
    active_d = active_q;
    if (cs && cpu_we && cpu_addr < 4'(NREGS)) begin
      shadow_d[cpu_addr] = cpu_dout;
      if (!ctrl[CTL_LATCH] || cpu_addr == CTRL)
        active_d[cpu_addr] = cpu_dout;
    end
    if (ctrl[CTL_LATCH] && hs && !hs_q)
      active_d = shadow_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_q <= '0;
      active_q <= '0;
      hs_q     <= 1'b0;
    end else begin
      shadow_q <= shadow_d;
      active_q <= active_d;
      hs_q     <= hs;
    end
  end

  layer_t [NLAYERS-1:0] s1_lyr_d, s1_lyr_q;
  cfg_t                 s1_cfg_d, s1_cfg_q;
  cfg_t                 s2_cfg_q;

  always_comb begin
    s1_lyr_d[0].valid = opaque(obj_pxl[3:0]);
    s1_lyr_d[0].prio  = obj_prio;
    s1_lyr_d[0].pxl   = obj_pxl;
    s1_lyr_d[1].valid = opaque(scr1_pxl[3:0]);
    s1_lyr_d[1].prio  = ctrl[CTL_P1] ? scr1_prio : active_q[PRIO1][4:0];
    s1_lyr_d[1].pxl   = {1'b0, scr1_pxl};
    s1_lyr_d[2].valid = opaque(scr2_pxl[3:0]);
    s1_lyr_d[2].prio  = ctrl[CTL_P2] ? scr2_prio : active_q[PRIO2][4:0];
    s1_lyr_d[2].pxl   = {1'b0, scr2_pxl};
    s1_lyr_d[3].valid = opaque(scr3_pxl[3:0]);
    s1_lyr_d[3].prio  = active_q[PRIO3][4:0];
    s1_lyr_d[3].pxl   = {1'b0, scr3_pxl};
    s1_lyr_d[4].valid = opaque(scr4_pxl[3:0]);
    s1_lyr_d[4].prio  = active_q[PRIO4][4:0];
    s1_lyr_d[4].pxl   = {1'b0, scr4_pxl};

    s1_cfg_d.blank    = ~lhbl | ~lvbl;
    s1_cfg_d.shd_en   = ctrl[CTL_SHD] & obj_shd;
    s1_cfg_d.thr      = active_q[SHTHR][4:0];
    s1_cfg_d.bank0    = active_q[BANK0][1:0];
    s1_cfg_d.bank1    = active_q[BANK0][4:2];
    s1_cfg_d.bank2    = active_q[BANK1][2:0];
    s1_cfg_d.bank3    = active_q[BANK1][5:3];
    s1_cfg_d.bank4    = active_q[BANK2][5:3];
    s1_cfg_d.backdrop = PAW'({active_q[BANK2][2:0], active_q[BDCOL][BDW-1:0]});
  end

  // Blank is folded into cfg so the blanked pixel still shifts through all three stages
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_lyr_q       <= '0;
      s1_cfg_q       <= '0;
      s1_cfg_q.blank <= 1'b1;
      s2_cfg_q       <= '0;
      s2_cfg_q.blank <= 1'b1;
    end else if (pxl_cen) begin
      s1_lyr_q <= s1_lyr_d;
      s1_cfg_q <= s1_cfg_d;
      s2_cfg_q <= s1_cfg_q;
    end
  end

  logic [2:0] win_idx;
  logic       win_found;
  logic [4:0] win_prio;
  logic [8:0] win_pxl;

  jtriders_prmix_cmp u_cmp (
    .clk       (clk),
    .rst_n     (rst_n),
    .cen       (pxl_cen),
    .lyr       (s1_lyr_q),
    .win_idx   (win_idx),
    .win_found (win_found),
    .win_prio  (win_prio),
    .win_pxl   (win_pxl)
  );

  logic [PAW-1:0] pal_addr_d, pal_addr_q;
  logic           shd_d, shd_q;
  logic [7:0]     st_dout_d, st_dout_q;

  always_comb begin
    pal_addr_d = s2_cfg_q.backdrop;
    if (win_found) begin
      case (win_idx)
        3'd0:    pal_addr_d = {s2_cfg_q.bank0, win_pxl};
        3'd1:    pal_addr_d = {s2_cfg_q.bank1, win_pxl[7:0]};
        3'd2:    pal_addr_d = {s2_cfg_q.bank2, win_pxl[7:0]};
        3'd3:    pal_addr_d = {s2_cfg_q.bank3, win_pxl[7:0]};
        3'd4:    pal_addr_d = {s2_cfg_q.bank4, win_pxl[7:0]};
        default: pal_addr_d = s2_cfg_q.backdrop;
      endcase
    end
    shd_d = s2_cfg_q.shd_en & (win_prio >= s2_cfg_q.thr);
    if (s2_cfg_q.blank) begin
      pal_addr_d = '0;
      shd_d      = 1'b0;
    end
    st_dout_d = (st_addr < 4'(NREGS)) ? active_q[st_addr] : 8'd0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pal_addr_q <= '0;
      shd_q      <= 1'b0;
      st_dout_q  <= 8'd0;
    end else begin
      st_dout_q <= st_dout_d;
      if (pxl_cen) begin
        pal_addr_q <= pal_addr_d;
        shd_q      <= shd_d;
      end
    end
  end

  assign pal_addr = pal_addr_q;
  assign shd      = shd_q;
  assign st_dout  = st_dout_q;

endmodule

// File: tb/tb_jtriders_prmix.sv
// Self-checking bench for jtriders_prmix: per-cycle model compare plus directed literal checks.
module tb_jtriders_prmix;

  logic        clk = 1'b0, rst_n = 1'b1, pxl_cen = 1'b0;
  logic        hs = 1'b0, lhbl = 1'b1, lvbl = 1'b1;
  logic        cs = 1'b0, cpu_we = 1'b0;
  logic [3:0]  cpu_addr = '0, st_addr = '0;
  logic [7:0]  cpu_dout = '0;
  logic [8:0]  obj_pxl = '0;
  logic [4:0]  obj_prio = '0, scr1_prio = '0, scr2_prio = '0;
  logic        obj_shd = 1'b0;
  logic [7:0]  scr1_pxl = '0, scr2_pxl = '0, scr3_pxl = '0, scr4_pxl = '0;
  logic [10:0] pal_addr;
  logic        shd;
  logic [7:0]  st_dout;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 0;
  int cyc      = 0;

  jtriders_prmix #(.BDW(8)) dut (
    .clk(clk), .rst_n(rst_n), .pxl_cen(pxl_cen), .hs(hs), .lhbl(lhbl), .lvbl(lvbl),
    .cs(cs), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_dout(cpu_dout),
    .obj_pxl(obj_pxl), .obj_prio(obj_prio), .obj_shd(obj_shd),
    .scr1_pxl(scr1_pxl), .scr2_pxl(scr2_pxl), .scr1_prio(scr1_prio), .scr2_prio(scr2_prio),
    .scr3_pxl(scr3_pxl), .scr4_pxl(scr4_pxl),
    .pal_addr(pal_addr), .shd(shd), .st_addr(st_addr), .st_dout(st_dout)
  );

  // Pixel enable is high on every other clock, changing at the falling edge
  initial forever begin
    #5 clk = 1'b1;
    #5 clk = 1'b0;
    cyc++;
    pxl_cen = cyc[0];
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time expired");
    $fatal(1, "[TB] watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: two register sets and a three-deep queue of finished pixels
  logic [7:0]  m_sh [10];
  logic [7:0]  m_ac [10];
  logic [10:0] m_pal [3];
  logic        m_shd [3];
  logic [7:0]  m_st;
  logic        m_hsq;

  function automatic logic [11:0] model_pix();
    int          pr [5];
    bit          op [5];
    logic [10:0] ad [5];
    int          best;
    int          wp;
    logic [10:0] a;
    logic        s;
    if (!lhbl || !lvbl) return 12'd0;
    op[0] = obj_pxl[3:0] != 0;  pr[0] = int'(obj_prio);
    ad[0] = {m_ac[6][1:0], obj_pxl};
    op[1] = scr1_pxl[3:0] != 0; pr[1] = m_ac[9][0] ? int'(scr1_prio) : int'(m_ac[0][4:0]);
    ad[1] = {m_ac[6][4:2], scr1_pxl};
    op[2] = scr2_pxl[3:0] != 0; pr[2] = m_ac[9][1] ? int'(scr2_prio) : int'(m_ac[1][4:0]);
    ad[2] = {m_ac[7][2:0], scr2_pxl};
    op[3] = scr3_pxl[3:0] != 0; pr[3] = int'(m_ac[2][4:0]);
    ad[3] = {m_ac[7][5:3], scr3_pxl};
    op[4] = scr4_pxl[3:0] != 0; pr[4] = int'(m_ac[3][4:0]);
    ad[4] = {m_ac[8][5:3], scr4_pxl};
    best = -1;
    for (int i = 0; i < 5; i++)
      if (op[i] && (best < 0 || pr[i] < pr[best])) best = i;
    if (best < 0) begin
      wp = 31;
      a  = {m_ac[8][2:0], m_ac[5]};
    end else begin
      wp = pr[best];
      a  = ad[best];
    end
    s = m_ac[9][2] & obj_shd & (wp >= int'(m_ac[4][4:0]));
    return {s, a};
  endfunction

  always @(posedge clk or negedge rst_n) begin
    logic [11:0] p;
    if (!rst_n) begin
      for (int i = 0; i < 10; i++) begin m_sh[i] = 0; m_ac[i] = 0; end
      for (int i = 0; i < 3; i++) begin m_pal[i] = 0; m_shd[i] = 0; end
      m_st  = 0;
      m_hsq = 0;
    end else begin
      if (pxl_cen) begin
        p = model_pix();
        m_pal[2] = m_pal[1]; m_shd[2] = m_shd[1];
        m_pal[1] = m_pal[0]; m_shd[1] = m_shd[0];
        m_pal[0] = p[10:0];  m_shd[0] = p[11];
      end
      m_st = (st_addr < 10) ? m_ac[st_addr] : 8'd0;
      if (cs && cpu_we && cpu_addr < 10) begin
        m_sh[cpu_addr] = cpu_dout;
        if (!m_ac[9][3] || cpu_addr == 9) m_ac[cpu_addr] = cpu_dout;
      end
      if (m_ac[9][3] && hs && !m_hsq)
        for (int i = 0; i < 10; i++) m_ac[i] = m_sh[i];
      m_hsq = hs;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("model_pal_addr", 32'(pal_addr), 32'(m_pal[2]));
      check("model_shd", 32'(shd), 32'(m_shd[2]));
      check("model_st_dout", 32'(st_dout), 32'(m_st));
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_pulses(input int n);
    repeat (2 * n) step();
  endtask

  task automatic write_reg(input logic [3:0] a, input logic [7:0] d);
    step();
    cs = 1'b1; cpu_we = 1'b1; cpu_addr = a; cpu_dout = d;
    step();
    cs = 1'b0; cpu_we = 1'b0;
  endtask

  task automatic apply_stimulus(input logic [8:0] o, input logic [4:0] op, input logic os,
                                input logic [7:0] s1, input logic [7:0] s2,
                                input logic [7:0] s3, input logic [7:0] s4);
    obj_pxl = o; obj_prio = op; obj_shd = os;
    scr1_pxl = s1; scr2_pxl = s2; scr3_pxl = s3; scr4_pxl = s4;
  endtask

  task automatic check_output(input string name, input logic [10:0] ep, input logic es);
    check({name, "_pal"}, 32'(pal_addr), 32'(ep));
    check({name, "_shd"}, 32'(shd), 32'(es));
  endtask

  initial begin
    int zc;
    #2 rst_n = 1'b0;
    #1;
    chk_en = 1;
    check_output("reset", 11'h000, 1'b0);
    check("reset_st_dout", 32'(st_dout), 32'h0);
    step(); step(); step();
    rst_n = 1'b1;

    apply_stimulus(9'h1A5, 5'd0, 1'b0, 8'h11, 8'h11, 8'h11, 8'h11);
    wait_pulses(4);
    check_output("tie_l0", 11'h1A5, 1'b0);

    write_reg(4'd2, 8'd3);
    write_reg(4'd3, 8'd1);
    write_reg(4'd8, 8'h28);
    apply_stimulus(9'h1A5, 5'd5, 1'b0, 8'h10, 8'h20, 8'h45, 8'h37);
    wait_pulses(4);
    check_output("l4_wins", 11'h537, 1'b0);

    write_reg(4'd5, 8'hC4);
    write_reg(4'd8, 8'h03);
    apply_stimulus(9'h1A0, 5'd5, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00);
    wait_pulses(4);
    check_output("backdrop", 11'h3C4, 1'b0);

    write_reg(4'd9, 8'h04);
    write_reg(4'd4, 8'h08);
    write_reg(4'd2, 8'd10);
    write_reg(4'd3, 8'd20);
    apply_stimulus(9'h1A0, 5'd0, 1'b1, 8'h00, 8'h00, 8'h45, 8'h37);
    wait_pulses(4);
    check_output("shadow_on", 11'h045, 1'b1);
    write_reg(4'd2, 8'd6);
    wait_pulses(4);
    check_output("shadow_off", 11'h045, 1'b0);
    apply_stimulus(9'h1A0, 5'd0, 1'b1, 8'h00, 8'h00, 8'h00, 8'h00);
    wait_pulses(4);
    check_output("shadow_bd", 11'h3C4, 1'b1);

    write_reg(4'd0, 8'd9);
    write_reg(4'd9, 8'h08);
    apply_stimulus(9'h1A0, 5'd0, 1'b1, 8'h12, 8'h00, 8'h45, 8'h00);
    wait_pulses(4);
    check_output("latch_pre", 11'h045, 1'b0);
    write_reg(4'd0, 8'd2);
    wait_pulses(4);
    check_output("latch_held", 11'h045, 1'b0);
    check("latch_held_st", 32'(st_dout), 32'd9);
    step(); hs = 1'b1;
    step(); hs = 1'b0;
    wait_pulses(4);
    check_output("latch_copied", 11'h012, 1'b0);
    check("latch_copied_st", 32'(st_dout), 32'd2);

    step();
    cs = 1'b1; cpu_we = 1'b1; cpu_addr = 4'd0; cpu_dout = 8'd9; hs = 1'b1;
    step();
    cs = 1'b0; cpu_we = 1'b0; hs = 1'b0;
    step();
    check("latch_same_clk_st", 32'(st_dout), 32'd9);
    wait_pulses(4);
    check_output("latch_same_clk", 11'h045, 1'b0);

    write_reg(4'd12, 8'hFF);
    st_addr = 4'd12;
    step(); step();
    check("unused_reg_st", 32'(st_dout), 32'h0);
    st_addr = 4'd9;

    for (int i = 0; i < 4 && pxl_cen != 1'b1; i++) step();
    lhbl = 1'b0;
    step();
    lhbl = 1'b1;
    zc = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (pal_addr == 11'h000) zc++;
    end
    check("blank_zero_cycles", 32'(zc), 32'd2);

    step();
    rst_n = 1'b0;
    #1;
    check_output("midline_reset", 11'h000, 1'b0);
    check("midline_reset_st", 32'(st_dout), 32'h0);
    step();
    rst_n = 1'b1;
    wait_pulses(4);
    check_output("after_reset", 11'h012, 1'b0);

    step();
    chk_en = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
